// File: rtl/qmca_pkg.sv
// QMCA ADC receiver shared definitions.
// States, default frame geometry and width helper.
package qmca_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      SHIFT
   } state_t;

   localparam int QMCA_ADC_BITS  = 16;
   localparam int QMCA_ADC_WIDTH = 14;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qmca_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Clears to 0 on reset.
module qmca_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // two-stage metastability filter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/qmca_adc_deser.sv
// Serial ADC frame deserializer framed by ADC_ENC.
// Emits one sample per good frame with alignment and error status.
module qmca_adc_deser
   import qmca_pkg::*;
#(
   parameter int BITS_PER_FRAME = QMCA_ADC_BITS,
   parameter int DATA_WIDTH     = QMCA_ADC_WIDTH,
   parameter int GOOD_FRAMES    = 4,
   parameter int ERR_CNT_WIDTH  = 16
) (
   input  logic                     ADC_CLK,
   input  logic                     RST_N,
   input  logic                     LOCKED,
   input  logic                     ENABLE,
   input  logic                     ADC_ENC,
   input  logic                     ADC_DIN,
   input  logic                     CLR_ERR,
   output logic [DATA_WIDTH-1:0]    DATA_OUT,
   output logic                     DATA_VALID,
   output logic                     ALIGNED,
   output logic [ERR_CNT_WIDTH-1:0] FRAME_ERR_CNT
);

   localparam int CW = cnt_width(BITS_PER_FRAME);
   localparam int GW = cnt_width(GOOD_FRAMES + 1);
   localparam logic [CW-1:0] LAST = CW'(BITS_PER_FRAME - 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(GOOD_FRAMES);

   state_t state;
   state_t state_nxt;

   logic lock_s;
   logic enc_d;
   logic rise;
   logic run;
   logic good_frame;
   logic early;
   logic missing;
   logic pend;

   logic [BITS_PER_FRAME-1:0] sr;
   logic [CW-1:0]             cnt;
   logic [GW-1:0]             good_cnt;
   logic [DATA_WIDTH-1:0]     hold;

   qmca_sync2 u_lock_sync (
      .clk  (ADC_CLK),
      .rst_n(RST_N),
      .d    (LOCKED),
      .q    (lock_s)
   );

   assign rise = ADC_ENC & ~enc_d;
   assign run  = lock_s & ENABLE;

   // state register
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // framing decisions and next state
   always_comb begin
      state_nxt  = state;
      good_frame = 1'b0;
      early      = 1'b0;
      missing    = 1'b0;
      if (!run) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: state_nxt = SEARCH;
            SEARCH: begin
               if (rise) state_nxt = SHIFT;
            end
            SHIFT: begin
               if (rise) begin
                  if (cnt == LAST) good_frame = 1'b1;
                  else             early      = 1'b1;
               end else if (cnt == LAST) begin
                  missing   = 1'b1;
                  state_nxt = SEARCH;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // encode edge history and serial capture, MSB first
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         enc_d <= 1'b0;
         sr    <= '0;
      end else begin
         enc_d <= ADC_ENC;
         sr    <= {sr[BITS_PER_FRAME-2:0], ADC_DIN};
      end
   end

   // bit position within the frame; held while idle
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (run && state != IDLE) begin
         if (rise)                cnt <= '0;
         else if (state == SHIFT) cnt <= cnt + CW'(1);
      end
   end

   // sample output, strobe and alignment tracking
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         DATA_OUT   <= '0;
         DATA_VALID <= 1'b0;
         ALIGNED    <= 1'b0;
         pend       <= 1'b0;
         hold       <= '0;
         good_cnt   <= '0;
      end else if (!run) begin
         DATA_VALID <= 1'b0;
         ALIGNED    <= 1'b0;
         pend       <= 1'b0;
         good_cnt   <= '0;
      end else begin
         DATA_VALID <= pend;
         pend       <= good_frame;
         if (good_frame) begin
            hold <= sr[BITS_PER_FRAME-1 -: DATA_WIDTH];
            if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + GW'(1);
         end
         if (early || missing) begin
            good_cnt <= '0;
            ALIGNED  <= 1'b0;
         end else if (pend) begin
            DATA_OUT <= hold;
            ALIGNED  <= (good_cnt == GOOD_MAX);
         end
      end
   end

   // saturating framing-error count; clear has priority
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         FRAME_ERR_CNT <= '0;
      end else if (CLR_ERR) begin
         FRAME_ERR_CNT <= '0;
      end else if ((early || missing) && FRAME_ERR_CNT != '1) begin
         FRAME_ERR_CNT <= FRAME_ERR_CNT + ERR_CNT_WIDTH'(1);
      end
   end

endmodule
